// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// requester count, index width, FSM encoding and the round-robin pick.
package rf_arb_pkg;

   localparam int NREQ  = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   // First set request bit found searching circularly upward from ptr.
   // Walking the offsets from high to low lets the smallest offset win.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0]  req,
                                                 input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      rr_pick = ptr;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = ptr + IDX_W'(k);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/onehot_dec_2x4.sv
// 2-bit index to 4-bit one-hot decoder with enable; all-zero when disabled.
module onehot_dec_2x4 (
   input  logic [1:0] i_idx,
   input  logic       i_en,
   output logic [3:0] o_onehot
);

   // Decode index to a single set bit, forced to zero when not enabled
   always_comb begin
      o_onehot = 4'b0000;
      if (i_en) o_onehot[i_idx] = 1'b1;
   end

endmodule

// File: rtl/rf_wr_port_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among
// ALU writeback, load unit, link-register update and debug write.
// A requester holds the port while its request stays high, but gives it up
// after MAX_BURST consecutive cycles whenever someone else is waiting.
module rf_wr_port_arbiter
   import rf_arb_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 4,
   parameter int MAX_BURST = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ*ADDR_W-1:0]   wr_addr_bus,
   input  logic [NREQ*DATA_W-1:0]   wr_data_bus,
   output logic [NREQ-1:0]          gnt,
   output logic [IDX_W-1:0]         gnt_idx,
   output logic                     busy,
   output logic                     rf_we,
   output logic [ADDR_W-1:0]        rf_addr,
   output logic [DATA_W-1:0]        rf_data
);

   // A 1-bit counter still works for MAX_BURST==1 (limit value is then 0).
   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   state_t             r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_gnt_idx;
   logic [CNT_W-1:0]   r_burst_cnt;

   logic               w_busy;
   logic               w_cur_req;
   logic [NREQ-1:0]    w_other_req;
   logic               w_others;
   logic               w_at_limit;
   logic               w_release;
   logic [IDX_W-1:0]   w_next_ptr;
   logic [ADDR_W-1:0]  w_sel_addr;
   logic [DATA_W-1:0]  w_sel_data;

   assign w_busy      = (r_state == ST_GRANT);
   assign w_cur_req   = req[r_gnt_idx];
   assign w_at_limit  = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
   assign w_next_ptr  = r_gnt_idx + IDX_W'(1);

   // Pending requests excluding the current owner
   always_comb begin
      w_other_req            = req;
      w_other_req[r_gnt_idx] = 1'b0;
   end

   assign w_others  = |w_other_req;
   assign w_release = !w_cur_req || (w_at_limit && w_others);

   // Arbitration FSM: winner index, round-robin pointer and burst length
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ptr       <= '0;
         r_gnt_idx   <= '0;
         r_burst_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_gnt_idx   <= rr_pick(req, r_ptr);
                  r_burst_cnt <= '0;
                  r_state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_release) begin
                  r_ptr       <= w_next_ptr;
                  r_burst_cnt <= '0;
                  // Hand over directly when someone else waits: no idle bubble
                  if (w_others) begin
                     r_gnt_idx <= rr_pick(w_other_req, w_next_ptr);
                  end else begin
                     r_state   <= ST_IDLE;
                  end
               end else if (!w_at_limit) begin
                  r_burst_cnt <= r_burst_cnt + CNT_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Grant lines come straight from the registered index, gated by busy
   onehot_dec_2x4 u_gnt_dec (
      .i_idx    (r_gnt_idx),
      .i_en     (w_busy),
      .o_onehot (gnt)
   );

   // Select the owner's address and data slices
   always_comb begin
      w_sel_addr = wr_addr_bus[ADDR_W*int'(r_gnt_idx) +: ADDR_W];
      w_sel_data = wr_data_bus[DATA_W*int'(r_gnt_idx) +: DATA_W];
   end

   // Write enable follows the owner's live request so a drop writes nothing;
   // reset clears the state asynchronously, so rf_we falls immediately.
   assign gnt_idx = r_gnt_idx;
   assign busy    = w_busy;
   assign rf_we   = w_busy && w_cur_req;
   assign rf_addr = rf_we ? w_sel_addr : '0;
   assign rf_data = rf_we ? w_sel_data : '0;

endmodule

// File: tb/tb_rf_wr_port_arbiter.sv
// Self-checking bench for rf_wr_port_arbiter: directed scenarios followed by
// a random request stream, all checked against a cycle-level reference model.
module tb_rf_wr_port_arbiter;

   localparam int DATA_W    = 32;
   localparam int ADDR_W    = 4;
   localparam int MAX_BURST = 4;
   localparam int WAIT_LIM  = 3 * MAX_BURST + 1;

   logic                   clk = 1'b0;
   logic                   reset = 1'b0;
   logic [3:0]             req = 4'b0000;
   logic [4*ADDR_W-1:0]    abus = '0;
   logic [4*DATA_W-1:0]    dbus = '0;
   logic [3:0]             gnt;
   logic [1:0]             gnt_idx;
   logic                   busy;
   logic                   rf_we;
   logic [ADDR_W-1:0]      rf_addr;
   logic [DATA_W-1:0]      rf_data;

   int n_vec  = 0;
   int n_miss = 0;

   // Reference model: who owns the port, how long it has held it, where the
   // next search starts.
   int m_busy  = 0;
   int m_owner = 0;
   int m_ptr   = 0;
   int m_held  = 0;

   int wait_cnt [4];
   bit written  [4];

   rf_wr_port_arbiter #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .wr_addr_bus (abus),
      .wr_data_bus (dbus),
      .gnt         (gnt),
      .gnt_idx     (gnt_idx),
      .busy        (busy),
      .rf_we       (rf_we),
      .rf_addr     (rf_addr),
      .rf_data     (rf_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [3:0] r, input int start);
      for (int k = 0; k < 4; k++) begin
         if (r[(start + k) % 4]) return (start + k) % 4;
      end
      return start;
   endfunction

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_ptr   = 0;
      m_held  = 0;
   endtask

   // Advance the model by one clock edge using the request vector seen there.
   task automatic model_edge();
      logic [3:0] others;
      if (reset) begin
         model_reset();
      end else if (m_busy == 0) begin
         if (req != 4'b0000) begin
            m_owner = pick(req, m_ptr);
            m_busy  = 1;
            m_held  = 1;
         end
      end else begin
         others = req;
         others[m_owner] = 1'b0;
         if (!req[m_owner] || (m_held >= MAX_BURST && others != 4'b0000)) begin
            m_ptr = (m_owner + 1) % 4;
            if (others != 4'b0000) begin
               m_owner = pick(others, m_ptr);
               m_held  = 1;
            end else begin
               m_busy = 0;
            end
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      logic [3:0]        e_gnt;
      logic              e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_data;
      e_gnt  = (m_busy != 0) ? (4'b0001 << m_owner) : 4'b0000;
      e_we   = (m_busy != 0) && req[m_owner];
      e_addr = e_we ? abus[m_owner*ADDR_W +: ADDR_W] : '0;
      e_data = e_we ? dbus[m_owner*DATA_W +: DATA_W] : '0;
      chk({tag, ".gnt"},     64'(gnt),     64'(e_gnt));
      chk({tag, ".gnt_idx"}, 64'(gnt_idx), 64'(m_owner));
      chk({tag, ".busy"},    64'(busy),    64'(m_busy != 0));
      chk({tag, ".rf_we"},   64'(rf_we),   64'(e_we));
      chk({tag, ".rf_addr"}, 64'(rf_addr), 64'(e_addr));
      chk({tag, ".rf_data"}, 64'(rf_data), 64'(e_data));
   endtask

   task automatic drive_bus(input logic [3:0] r, input logic [4*ADDR_W-1:0] a,
                            input logic [4*DATA_W-1:0] d, input string tag);
      req  = r;
      abus = a;
      dbus = d;
      #1;
      compare_all(tag);
   endtask

   task automatic drive(input logic [3:0] r, input string tag);
      drive_bus(r, 16'($urandom), {$urandom, $urandom, $urandom, $urandom}, tag);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      #1;
      model_edge();
      compare_all(tag);
   endtask

   initial begin
      logic [3:0] r;
      int worst;

      // Test 1: reset with every request up, then first grant to index 0
      #1 reset = 1'b1;
      model_reset();
      drive(4'b1111, "t1_rst");
      chk("t1_rst_gnt", 64'(gnt), 64'h0);
      chk("t1_rst_we", 64'(rf_we), 64'h0);
      step("t1_rst_hold");
      #2 reset = 1'b0;
      step("t1_first");
      chk("t1_gnt", 64'(gnt), 64'b0001);
      chk("t1_addr", 64'(rf_addr), 64'(abus[3:0]));
      drive(4'b0000, "t1_drop");
      step("t1_idle");

      // Test 2: two contenders alternate in bursts of MAX_BURST, no bubble
      drive(4'b1010, "t2_req");
      for (int k = 0; k < 9; k++) begin
         step("t2");
         chk("t2_gnt", 64'(gnt), (k < 4 || k >= 8) ? 64'b0010 : 64'b1000);
         chk("t2_we", 64'(rf_we), 64'h1);
      end
      drive(4'b0000, "t2_drop");
      step("t2_idle");

      // Test 3: lone requester keeps the port; drop releases to IDLE
      drive(4'b0100, "t3_req");
      for (int k = 0; k < 10; k++) begin
         step("t3");
         chk("t3_gnt", 64'(gnt), 64'b0100);
         chk("t3_we", 64'(rf_we), 64'h1);
      end
      drive(4'b0000, "t3_drop");
      chk("t3_drop_we", 64'(rf_we), 64'h0);
      step("t3_idle");
      chk("t3_idle_busy", 64'(busy), 64'h0);

      // Test 4: with ptr at 3, index 3 wins first, then wrap to 0
      drive(4'b1001, "t4_req");
      for (int k = 0; k < 5; k++) begin
         step("t4");
         chk("t4_gnt", 64'(gnt), (k < 4) ? 64'b1000 : 64'b0001);
      end
      drive(4'b0000, "t4_drop");
      step("t4_idle");

      // Test 5: asynchronous reset in the middle of a burst
      drive_bus(4'b0010, 16'h00A0, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0}, "t5_req");
      step("t5_a");
      chk("t5_addr", 64'(rf_addr), 64'hA);
      chk("t5_data", 64'(rf_data), 64'hDEADBEEF);
      step("t5_b");
      #2 reset = 1'b1;
      model_reset();
      #1;
      chk("t5_rst_we", 64'(rf_we), 64'h0);
      compare_all("t5_rst");
      drive(4'b1111, "t5_rst_req");
      step("t5_rst_hold");
      #2 reset = 1'b0;
      step("t5_after");
      chk("t5_ptr0_gnt", 64'(gnt), 64'b0001);
      drive(4'b0000, "t5_drop");
      step("t5_idle");

      // Test 6: random request stream with fairness bound
      for (int i = 0; i < 4; i++) begin
         wait_cnt[i] = 0;
         written[i]  = 1'b0;
      end
      for (int cyc = 0; cyc < 2000; cyc++) begin
         r = req;
         for (int i = 0; i < 4; i++) begin
            if (!r[i]) begin
               if ($urandom_range(3) == 0) r[i] = 1'b1;
            end else if (written[i] && $urandom_range(2) == 0) begin
               r[i] = 1'b0;
               written[i] = 1'b0;
            end
         end
         drive(r, "t6_drv");
         step("t6");
         chk("t6_onehot0", 64'($onehot0(gnt)), 64'h1);
         chk("t6_we_req", 64'(!rf_we || req[gnt_idx]), 64'h1);
         worst = 0;
         for (int i = 0; i < 4; i++) begin
            if (rf_we && gnt_idx == 2'(i)) begin
               written[i]  = 1'b1;
               wait_cnt[i] = 0;
            end else if (req[i]) begin
               wait_cnt[i]++;
            end else begin
               wait_cnt[i] = 0;
            end
            if (wait_cnt[i] > worst) worst = wait_cnt[i];
         end
         chk("t6_wait_bound", 64'(worst <= WAIT_LIM), 64'h1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
